// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: PC-select codes from the branch unit.
// The optional misalignment trap is enabled by the PC_MISALIGN_TRAP_EN macro.
package pc_fetch_unit_pkg;

    localparam logic [1:0] PC_MUX_PC4     = 2'b00;
    localparam logic [1:0] PC_MUX_BRANCH  = 2'b01;
    localparam logic [1:0] PC_MUX_ALU_OUT = 2'b10;

    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == PC_MUX_BRANCH) || (sel == PC_MUX_ALU_OUT);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selection: sequential PC, redirect target and redirect flag.
// With PC_MISALIGN_TRAP_EN defined it also reports a misaligned redirect target.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  branch,
    input  logic [31:0] branch_target,
    input  logic [31:0] alu_result,
    output logic [31:0] seq_pc,
    output logic [31:0] target,
    output logic        redirect
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    logic [31:0] raw_target;

    always_comb begin
        seq_pc = pc + 32'd4;
        case (branch)
            PC_MUX_BRANCH:  raw_target = branch_target;
            PC_MUX_ALU_OUT: raw_target = alu_result & ~32'd1;
            default:        raw_target = seq_pc;
        endcase
        redirect = is_redirect(branch);
        // Fetch addresses are always word aligned, whatever the source supplied.
        target   = raw_target & ~32'd3;
`ifdef PC_MISALIGN_TRAP_EN
        misaligned = redirect && (raw_target[1:0] != 2'b00);
`endif
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC generator and IF/ID register with instruction-memory request handshake and redirects.
// Optional sticky misalignment trap enabled by the PC_MISALIGN_TRAP_EN macro.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  branch,
    input  logic [31:0] branch_target,
    input  logic [31:0] alu_result,
    input  logic        stall,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_gnt,
    input  logic [31:0] if_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        flush,
    output logic        misalign_trap
);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, FETCH, REDIR_WAIT, TRAP} state_t;
`else
    typedef enum logic [1:0] {BOOT, FETCH, REDIR_WAIT} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        redirect;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    pc_next_sel u_next_sel (
        .pc            (pc),
        .branch        (branch),
        .branch_target (branch_target),
        .alu_result    (alu_result),
        .seq_pc        (seq_pc),
        .target        (target),
        .redirect      (redirect)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    // The PC register only moves once a pending request is granted, so it is the fetch address.
    assign if_addr = pc;

`ifndef PC_MISALIGN_TRAP_EN
    assign misalign_trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            redir_pc <= 32'd0;
            if_req   <= 1'b0;
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
            flush    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            flush <= 1'b0;
            case (state)
                BOOT: begin
                    state  <= FETCH;
                    if_req <= 1'b1;
                end
                FETCH: begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        misalign_trap <= 1'b1;
                        id_valid      <= 1'b0;
                        flush         <= 1'b1;
                        if_req        <= 1'b0;
                        state         <= TRAP;
                    end else
`endif
                    if (redirect) begin
                        id_valid <= 1'b0;
                        if (if_gnt) begin
                            pc    <= target;
                            flush <= 1'b1;
                        end else begin
                            redir_pc <= target;
                            state    <= REDIR_WAIT;
                        end
                    end else if (!stall) begin
                        if (if_gnt) begin
                            pc       <= seq_pc;
                            id_pc    <= pc;
                            id_inst  <= if_rdata;
                            id_valid <= 1'b1;
                        end else begin
                            id_valid <= 1'b0;
                        end
                    end
                end
                REDIR_WAIT: begin
                    // The granted data belongs to the old address and is dropped; youngest redirect wins.
`ifdef PC_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        misalign_trap <= 1'b1;
                        id_valid      <= 1'b0;
                        flush         <= 1'b1;
                        if_req        <= 1'b0;
                        state         <= TRAP;
                    end else
`endif
                    if (if_gnt) begin
                        pc       <= redirect ? target : redir_pc;
                        flush    <= 1'b1;
                        id_valid <= 1'b0;
                        state    <= FETCH;
                    end else if (redirect) begin
                        redir_pc <= target;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
